float_point_normalizer: RTL

- Post-add normalize-and-round stage; sits directly downstream of the float-point adder datapath.
- Takes the raw extended sum/difference (sign, baseline biased exponent, carry+hidden+fraction+GRS mantissa) and returns a normalized, rounded IEEE-754 sign/exponent/fraction triple.
- Uses the codebase valid/issue_ack handshake on both sides.

---
 rtl/float_point_normalizer_pkg.sv | 25 ++
 rtl/float_point_normalizer_leading_zero_counter.sv | 20 ++
 rtl/float_point_normalizer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/float_point_normalizer_pkg.sv
// Shared widths, FSM encodings and raw-mantissa layout for the post-add normalize/round stage.
package float_point_normalizer_pkg;

  localparam int unsigned DOUBLE_POINT_NUMBER_EXPONENT_WIDTH_IN_BITS = 11;
  localparam int unsigned DOUBLE_POINT_NUMBER_FRACTION_WIDTH_IN_BITS = 52;

  localparam logic [1:0] FLOAT_POINT_NORMALIZER_STATE_IDLE      = 2'd0;
  localparam logic [1:0] FLOAT_POINT_NORMALIZER_STATE_NORMALIZE = 2'd1;
  localparam logic [1:0] FLOAT_POINT_NORMALIZER_STATE_ROUND     = 2'd2;
  localparam logic [1:0] FLOAT_POINT_NORMALIZER_STATE_OUTPUT    = 2'd3;

  // Raw mantissa layout, MSB to LSB: carry, hidden, fraction, guard, round, sticky.
  localparam int unsigned RAW_STICKY_BIT = 0;
  localparam int unsigned RAW_ROUND_BIT  = 1;
  localparam int unsigned RAW_GUARD_BIT  = 2;

  function automatic int unsigned raw_hidden_bit(input int unsigned fraction_width);
    return fraction_width + 3;
  endfunction

  function automatic int unsigned raw_carry_bit(input int unsigned fraction_width);
    return fraction_width + 4;
  endfunction

endpackage

// File: rtl/float_point_normalizer_leading_zero_counter.sv
// Combinational leading-zero count of a WIDTH-bit vector; all-zero input returns WIDTH.
module float_point_normalizer_leading_zero_counter #(
  parameter  int unsigned WIDTH       = 56,
  localparam int unsigned COUNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]       value,
  output logic [COUNT_WIDTH-1:0] zero_count_c
);

  // Ascending scan: the highest set bit is the last one to write the count.
  always_comb begin
    zero_count_c = COUNT_WIDTH'(WIDTH);
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (value[i]) begin
        zero_count_c = COUNT_WIDTH'(int'(WIDTH) - 1 - i);
      end
    end
  end

endmodule

// File: rtl/float_point_normalizer.sv
// Normalize-and-round stage behind the float-point adder (valid/issue_ack on both sides).
// Define FLOAT_POINT_NORMALIZER_CHOP_ROUND_EN to truncate instead of round-to-nearest-even.
module float_point_normalizer
  import float_point_normalizer_pkg::*;
#(
  parameter  int unsigned EXPONENT_WIDTH_IN_BITS     = DOUBLE_POINT_NUMBER_EXPONENT_WIDTH_IN_BITS,
  parameter  int unsigned FRACTION_WIDTH_IN_BITS     = DOUBLE_POINT_NUMBER_FRACTION_WIDTH_IN_BITS,
  localparam int unsigned RAW_MANTISSA_WIDTH_IN_BITS = FRACTION_WIDTH_IN_BITS + 5
) (
  input  logic                                  clk_in,
  input  logic                                  reset_in,
  input  logic                                  raw_valid_in,
  input  logic                                  raw_sign_in,
  input  logic [EXPONENT_WIDTH_IN_BITS-1:0]     raw_exponent_in,
  input  logic [RAW_MANTISSA_WIDTH_IN_BITS-1:0] raw_mantissa_in,
  output logic                                  issue_ack_out,
  output logic                                  result_valid_out,
  output logic                                  result_sign_out,
  output logic [EXPONENT_WIDTH_IN_BITS-1:0]     result_exponent_out,
  output logic [FRACTION_WIDTH_IN_BITS-1:0]     result_fraction_out,
  output logic                                  overflow_out,
  input  logic                                  issue_ack_in
);

  localparam int unsigned EW         = EXPONENT_WIDTH_IN_BITS;
  localparam int unsigned FW         = FRACTION_WIDTH_IN_BITS;
  localparam int unsigned MW         = RAW_MANTISSA_WIDTH_IN_BITS;
  localparam int unsigned XW         = EW + 1;
  localparam int unsigned CARRY_BIT  = raw_carry_bit(FW);
  localparam int unsigned HIDDEN_BIT = raw_hidden_bit(FW);
  localparam int unsigned LZ_IN_W    = HIDDEN_BIT + 1;
  localparam int unsigned LZ_W       = $clog2(LZ_IN_W + 1);
  localparam logic [XW-1:0] EXP_ALL_ONES = {1'b0, {EW{1'b1}}};

  logic [1:0]    state_q, state_d;

  logic          sign_q;
  logic [EW-1:0] exp_q;
  logic [MW-1:0] mant_q;

  logic          nsign_q;
  logic [XW-1:0] nexp_q;
  logic [MW-1:0] nmant_q;

  logic [LZ_W-1:0] lz_c;
  logic [XW-1:0]   exp_ext_c, lz_ext_c;
  logic            norm_sign_c;
  logic [XW-1:0]   norm_exp_c;
  logic [MW-1:0]   norm_mant_c;

  logic            round_up_c;
  logic [FW+1:0]   round_sum_c;
  logic [XW-1:0]   round_exp_c;
  logic [FW-1:0]   round_frac_c;
  logic            round_ovf_c;

  assign issue_ack_out = reset_in && (state_q == FLOAT_POINT_NORMALIZER_STATE_IDLE);

  always_ff @(posedge clk_in) begin
    if (!reset_in) state_q <= FLOAT_POINT_NORMALIZER_STATE_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FLOAT_POINT_NORMALIZER_STATE_IDLE:
        if (raw_valid_in) state_d = FLOAT_POINT_NORMALIZER_STATE_NORMALIZE;
      FLOAT_POINT_NORMALIZER_STATE_NORMALIZE: state_d = FLOAT_POINT_NORMALIZER_STATE_ROUND;
      FLOAT_POINT_NORMALIZER_STATE_ROUND:     state_d = FLOAT_POINT_NORMALIZER_STATE_OUTPUT;
      FLOAT_POINT_NORMALIZER_STATE_OUTPUT:
        if (issue_ack_in) state_d = FLOAT_POINT_NORMALIZER_STATE_IDLE;
      default: state_d = FLOAT_POINT_NORMALIZER_STATE_IDLE;
    endcase
  end

  float_point_normalizer_leading_zero_counter #(
    .WIDTH (LZ_IN_W)
  ) u_leading_zero_counter (
    .value        (mant_q[HIDDEN_BIT:0]),
    .zero_count_c (lz_c)
  );

  assign exp_ext_c = {1'b0, exp_q};
  assign lz_ext_c  = XW'(lz_c);

  // Left shifts stop early once the exponent would fall below the subnormal scale.
  always_comb begin
    norm_sign_c = sign_q;
    norm_exp_c  = exp_ext_c;
    norm_mant_c = mant_q;
    if (mant_q == '0) begin
      norm_sign_c = 1'b0;
      norm_exp_c  = '0;
    end else if (mant_q[CARRY_BIT]) begin
      norm_mant_c                 = {1'b0, mant_q[MW-1:1]};
      norm_mant_c[RAW_STICKY_BIT] = mant_q[RAW_ROUND_BIT] | mant_q[RAW_STICKY_BIT];
      norm_exp_c                  = exp_ext_c + XW'(1);
    end else if (exp_ext_c > lz_ext_c) begin
      norm_mant_c = mant_q << lz_c;
      norm_exp_c  = exp_ext_c - lz_ext_c;
    end else if (exp_ext_c != '0) begin
      norm_mant_c = mant_q << (exp_ext_c - XW'(1));
      norm_exp_c  = '0;
    end
  end

`ifdef FLOAT_POINT_NORMALIZER_CHOP_ROUND_EN
  assign round_up_c = 1'b0;
`else
  assign round_up_c = nmant_q[RAW_GUARD_BIT]
                    & (nmant_q[RAW_ROUND_BIT] | nmant_q[RAW_STICKY_BIT] | nmant_q[RAW_GUARD_BIT+1]);
`endif

  // Carry bit rides along in the sum so a round past the hidden bit shows up at the top.
  always_comb begin
    round_sum_c  = nmant_q[CARRY_BIT:RAW_GUARD_BIT+1] + (FW+2)'(round_up_c);
    round_exp_c  = nexp_q;
    round_frac_c = round_sum_c[FW-1:0];
    round_ovf_c  = 1'b0;
    if (round_sum_c[FW+1]) begin
      round_exp_c  = nexp_q + XW'(1);
      round_frac_c = '0;
    end else if ((nexp_q == '0) && round_sum_c[FW]) begin
      round_exp_c = XW'(1);
    end
    if (round_exp_c >= EXP_ALL_ONES) begin
      round_exp_c  = EXP_ALL_ONES;
      round_frac_c = '0;
      round_ovf_c  = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      sign_q              <= 1'b0;
      exp_q               <= '0;
      mant_q              <= '0;
      nsign_q             <= 1'b0;
      nexp_q              <= '0;
      nmant_q             <= '0;
      result_valid_out    <= 1'b0;
      result_sign_out     <= 1'b0;
      result_exponent_out <= '0;
      result_fraction_out <= '0;
      overflow_out        <= 1'b0;
    end else begin
      case (state_q)
        FLOAT_POINT_NORMALIZER_STATE_IDLE: begin
          if (raw_valid_in) begin
            sign_q <= raw_sign_in;
            exp_q  <= raw_exponent_in;
            mant_q <= raw_mantissa_in;
          end
        end
        FLOAT_POINT_NORMALIZER_STATE_NORMALIZE: begin
          nsign_q <= norm_sign_c;
          nexp_q  <= norm_exp_c;
          nmant_q <= norm_mant_c;
        end
        FLOAT_POINT_NORMALIZER_STATE_ROUND: begin
          result_valid_out    <= 1'b1;
          result_sign_out     <= nsign_q;
          result_exponent_out <= round_exp_c[EW-1:0];
          result_fraction_out <= round_frac_c;
          overflow_out        <= round_ovf_c;
        end
        FLOAT_POINT_NORMALIZER_STATE_OUTPUT: begin
          if (issue_ack_in) result_valid_out <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
